dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Serial transmitter that drives a 12-bit SPI DAC (DAC121S101-class).
- Generates the DAC's SCLK, SYNC (active-low chip select) and SDATA from the system clock; the FPGA is the clock master.
- Shifts out one 16-bit frame per request, MSB first.
- Sits beside the serial ADC receive path and is the output side of the same serial data chain: processed samples go out through this block.

Parameters:
- DIV, default 2: system clocks per SCLK half-period; legal range 1..255. SCLK period = 2*DIV clk.
- DATA_W, default 12: DAC data width. The frame is always 16 bits; DATA_W must be ≤ 12.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one frame; sampled only in Idle.
- data_in  in  DATA_W  sample to send; latched on accepted start.
- SCLK  out  1  serial clock to DAC; idles high.
- SYNC  out  1  active-low frame select to DAC.
- SDATA  out  1  serial data; changes on SCLK rising edge, DAC samples on falling edge.
- busy  out  1  high while a frame is in progress.
- tx_done_tick  out  1  one-clk pulse at end of frame.

Behaviour:
- Reset (reset=0, async, any state including mid-frame):
  - state = Idle; SYNC=1, SCLK=1, SDATA=0, busy=0, tx_done_tick=0.
  - Shift register, bit counter n and divider counter all cleared.
  - A partial frame is aborted; no tick is produced.
- Frame word: {2'b00, PD[1:0], data_in left-aligned in bits 11:0, zero-padded below}. PD=2'b00 unless POWER_DOWN_EN.
- All outputs are registered. State machine states:
  - Idle:
    - SYNC=1, SCLK=1, busy=0.
    - start=1 at edge T → load shift register with frame; at T+1 enter Enviar with SYNC=0, SDATA=frame[15], SCLK=1, n=0, div=0, busy=1.
  - Enviar:
    - div counts 0..DIV-1; on wrap, SCLK toggles.
    - SCLK 1→0 toggle: the DAC samples. SDATA is unchanged.
    - SCLK 0→1 toggle with n<15: n++, shift, SDATA = next bit.
    - SCLK 0→1 toggle with n==15: enter Fin with SYNC=1 and SDATA=0.
  - Fin:
    - Hold SYNC=1, SCLK=1 for DIV clks (minimum SYNC-high time).
    - Then pulse tx_done_tick=1 for one clk, with busy=0 in that same clk, and return to Idle.
- Latency, with start accepted at cycle 0:
  - SYNC falls at cycle 1.
  - SYNC rises at cycle 1+32*DIV.
  - tx_done_tick at cycle 1+33*DIV.
- Back-to-back: start=1 in the tx_done_tick cycle is accepted; the next SYNC fall is one clk later.
- start while busy=1 is ignored, not queued. data_in changes mid-frame do not affect the frame in flight.
- Exactly 16 SCLK falling edges occur per frame while SYNC=0. SCLK never toggles while SYNC=1.

Optional Feature:
- Macro: POWER_DOWN_EN.
- Defined:
  - Adds input pd_mode[1:0], latched with data_in on accepted start.
  - Frame bits 13:12 = pd_mode (00 normal; 01/10/11 DAC power-down modes).
- Undefined:
  - No pd_mode port.
  - Bits 13:12 are forced to 00; DAC always runs in normal mode.

Test Plan:
1. DIV=2, data_in=12'hA5C, one-clk start → SYNC low at cycle 1; the bits captured on the 16 SCLK falling edges equal 0000_1010_0101_1100; SYNC high at cycle 65; tx_done_tick single pulse at cycle 67; busy high cycles 1..66.
2. Hold start=1 continuously with data_in alternating 12'hFFF then 12'h000 → back-to-back frames 16'h0FFF then 16'h0000; SYNC-high gap between frames is exactly DIV+1 clks; one tick per frame.
3. Pulse start again at cycle 10 of a frame, with data_in changed to 12'h123 → the pulse is ignored; the frame in flight is unchanged; no second frame follows.
4. Drive reset=0 at cycle 20 of a frame (DIV=2) → in the same clk SYNC=1, SCLK=1, SDATA=0, busy=0; no tick; after release a new start sends a complete, correct frame.
5. DIV=1, data_in=12'h800 → SCLK period 2 clks; frame 16'h0800 received; tx_done_tick at cycle 34.
6. POWER_DOWN_EN defined, pd_mode=2'b11, data_in=12'h000 → frame 16'h3000. Same stimulus without the macro → frame 16'h0000.

Source files
------------

// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 12-bit DAC121S101-class converter: one 16-bit frame per start, MSB first.
// Define POWER_DOWN_EN to add the pd_mode input that drives frame bits 13:12.
module dac_spi_tx #(
    parameter int DIV    = 2,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
`ifdef POWER_DOWN_EN
    input  logic [1:0]        pd_mode,
`endif
    output logic              SCLK,
    output logic              SYNC,
    output logic              SDATA,
    output logic              busy,
    output logic              tx_done_tick
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENVIAR = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  n_q, n_d;
    logic [7:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        sync_q, sync_d;
    logic        sdata_q, sdata_d;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;

    logic [1:0]  pd_s;
    logic [11:0] data_al_s;
    logic [15:0] frame_s;
    logic        div_wrap_s;

`ifdef POWER_DOWN_EN
    assign pd_s = pd_mode;
`else
    assign pd_s = 2'b00;
`endif

    // Left-align the sample in the 12-bit data field, zero-padding the LSBs.
    assign data_al_s  = 12'(data_in) << (12 - DATA_W);
    assign frame_s    = {2'b00, pd_s, data_al_s};
    assign div_wrap_s = (div_q == 8'(DIV - 1));

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= 16'h0000;
            n_q     <= 4'd0;
            div_q   <= 8'd0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            n_q     <= n_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        n_d     = n_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        sync_d  = sync_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sync_d  = 1'b1;
                sclk_d  = 1'b1;
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    shreg_d = frame_s;
                    sdata_d = frame_s[15];
                    sync_d  = 1'b0;
                    n_d     = 4'd0;
                    div_d   = 8'd0;
                    busy_d  = 1'b1;
                    state_d = ST_ENVIAR;
                end else begin
                    div_d = 8'd0;
                end
            end
            ST_ENVIAR: begin
                if (div_wrap_s) begin
                    div_d = 8'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else begin
                        // Rising SCLK edge: advance data, or close the frame after bit 0.
                        sclk_d = 1'b1;
                        if (n_q != 4'd15) begin
                            n_d     = n_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                            sdata_d = shreg_q[14];
                        end else begin
                            sync_d  = 1'b1;
                            sdata_d = 1'b0;
                            state_d = ST_FIN;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_FIN: begin
                if (div_wrap_s) begin
                    div_d   = 8'd0;
                    tick_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                sync_d  = 1'b1;
                sclk_d  = 1'b1;
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                div_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SCLK         = sclk_q;
    assign SYNC         = sync_q;
    assign SDATA        = sdata_q;
    assign busy         = busy_q;
    assign tx_done_tick = tick_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a DIV=2 instance and a DIV=1 instance observed by one
// negedge monitor that decodes frames, SYNC/busy edges and ticks with cycle stamps.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [11:0] data0 = 12'h000, data1 = 12'h000;
    logic [1:0]  pd0 = 2'b00, pd1 = 2'b00;
    logic        sclk0, sync0, sdata0, busy0, tick0;
    logic        sclk1, sync1, sdata1, busy1, tick1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mon_sel = 0;
    int sclk_bad = 0;
    int busy_at_tick_bad = 0;
    int q_fall[$], q_rise[$], q_frame[$], q_nf[$], q_tick[$], q_brise[$], q_bfall[$];

    always #5 clk = ~clk;

    dac_spi_tx #(.DIV(2), .DATA_W(12)) dut (
        .clk(clk), .reset(reset), .start(start0), .data_in(data0),
`ifdef POWER_DOWN_EN
        .pd_mode(pd0),
`endif
        .SCLK(sclk0), .SYNC(sync0), .SDATA(sdata0), .busy(busy0), .tx_done_tick(tick0)
    );

    dac_spi_tx #(.DIV(1), .DATA_W(12)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .data_in(data1),
`ifdef POWER_DOWN_EN
        .pd_mode(pd1),
`endif
        .SCLK(sclk1), .SYNC(sync1), .SDATA(sdata1), .busy(busy1), .tx_done_tick(tick1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Monitor: cycle stamps of SYNC/busy edges and ticks, bits taken on SCLK falling edges.
    initial begin
        logic ps = 1'b1, pk = 1'b1, pb = 1'b0;
        logic s, k, d, b, t;
        logic [15:0] bits = 16'h0000;
        int nf = 0;
        forever begin
            @(negedge clk);
            cyc++;
            s = mon_sel ? sync1 : sync0;
            k = mon_sel ? sclk1 : sclk0;
            d = mon_sel ? sdata1 : sdata0;
            b = mon_sel ? busy1 : busy0;
            t = mon_sel ? tick1 : tick0;
            if (ps && !s) begin q_fall.push_back(cyc); bits = 16'h0000; nf = 0; end
            if (!ps && s) begin q_rise.push_back(cyc); q_frame.push_back(int'(bits)); q_nf.push_back(nf); end
            if (!s && pk && !k) begin bits = {bits[14:0], d}; nf++; end
            if (s && !k) sclk_bad++;
            if (!pb && b) q_brise.push_back(cyc);
            if (pb && !b) q_bfall.push_back(cyc);
            if (t) begin q_tick.push_back(cyc); if (b) busy_at_tick_bad++; end
            ps = s; pk = k; pb = b;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Pulse start for one clock on the selected instance; returns the accept cycle (cycle 0).
    task automatic send(input int sel, input logic [11:0] d, input logic [1:0] pd, output int c0);
        @(negedge clk);
        #1;
        c0 = cyc;
        if (sel == 0) begin start0 = 1'b1; data0 = d; pd0 = pd; end
        else begin start1 = 1'b1; data1 = d; pd1 = pd; end
        goto(c0 + 1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        int c0, bf, br, bt, bfr, bbr, bbf;
        goto(3);
        check_eq("rst_sync", 32'(sync0), 32'd1);
        check_eq("rst_sclk", 32'(sclk0), 32'd1);
        check_eq("rst_sdata", 32'(sdata0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_tick", 32'(tick0), 32'd0);
        reset = 1'b1;
        goto(6);

        // Single frame, DIV=2.
        bf = q_fall.size(); bfr = q_frame.size(); bt = q_tick.size(); bbr = q_brise.size(); bbf = q_bfall.size();
        send(0, 12'hA5C, 2'b00, c0);
        goto(c0 + 80);
        check_eq("t1_sync_fall", 32'(qget(q_fall, bf) - c0), 32'd1);
        check_eq("t1_sync_rise", 32'(qget(q_rise, bfr) - c0), 32'd65);
        check_eq("t1_frame", 32'(qget(q_frame, bfr)), 32'h0A5C);
        check_eq("t1_nfall", 32'(qget(q_nf, bfr)), 32'd16);
        check_eq("t1_tick_cyc", 32'(qget(q_tick, bt) - c0), 32'd67);
        check_eq("t1_tick_cnt", 32'(q_tick.size() - bt), 32'd1);
        check_eq("t1_busy_rise", 32'(qget(q_brise, bbr) - c0), 32'd1);
        check_eq("t1_busy_fall", 32'(qget(q_bfall, bbf) - c0), 32'd67);

        // Back-to-back with start held high.
        bf = q_fall.size(); br = q_rise.size(); bfr = q_frame.size(); bt = q_tick.size();
        @(negedge clk);
        #1;
        c0 = cyc;
        start0 = 1'b1;
        data0 = 12'hFFF;
        goto(c0 + 1);
        data0 = 12'h000;
        goto(c0 + 70);
        start0 = 1'b0;
        goto(c0 + 150);
        check_eq("t2_frame_a", 32'(qget(q_frame, bfr)), 32'h0FFF);
        check_eq("t2_frame_b", 32'(qget(q_frame, bfr + 1)), 32'h0000);
        check_eq("t2_gap", 32'(qget(q_fall, bf + 1) - qget(q_rise, br)), 32'd3);
        check_eq("t2_frames", 32'(q_fall.size() - bf), 32'd2);
        check_eq("t2_ticks", 32'(q_tick.size() - bt), 32'd2);

        // start mid-frame is ignored.
        bf = q_fall.size(); bfr = q_frame.size(); bt = q_tick.size();
        send(0, 12'h456, 2'b00, c0);
        goto(c0 + 10);
        start0 = 1'b1;
        data0 = 12'h123;
        goto(c0 + 11);
        start0 = 1'b0;
        goto(c0 + 150);
        check_eq("t3_frame", 32'(qget(q_frame, bfr)), 32'h0456);
        check_eq("t3_frames", 32'(q_fall.size() - bf), 32'd1);
        check_eq("t3_ticks", 32'(q_tick.size() - bt), 32'd1);

        // Asynchronous reset mid-frame, then a clean frame.
        bt = q_tick.size();
        send(0, 12'h3C3, 2'b00, c0);
        goto(c0 + 20);
        reset = 1'b0;
        #1;
        check_eq("t4_sync", 32'(sync0), 32'd1);
        check_eq("t4_sclk", 32'(sclk0), 32'd1);
        check_eq("t4_sdata", 32'(sdata0), 32'd0);
        check_eq("t4_busy", 32'(busy0), 32'd0);
        goto(c0 + 23);
        reset = 1'b1;
        goto(c0 + 100);
        check_eq("t4_no_tick", 32'(q_tick.size() - bt), 32'd0);
        bfr = q_frame.size(); bt = q_tick.size();
        send(0, 12'h9E1, 2'b00, c0);
        goto(c0 + 80);
        check_eq("t4_frame", 32'(qget(q_frame, bfr)), 32'h09E1);
        check_eq("t4_nfall", 32'(qget(q_nf, bfr)), 32'd16);
        check_eq("t4_tick_cyc", 32'(qget(q_tick, bt) - c0), 32'd67);

        // DIV=1 instance.
        mon_sel = 1;
        bf = q_fall.size(); bfr = q_frame.size(); bt = q_tick.size();
        send(1, 12'h800, 2'b00, c0);
        goto(c0 + 45);
        check_eq("t5_sync_fall", 32'(qget(q_fall, bf) - c0), 32'd1);
        check_eq("t5_sync_rise", 32'(qget(q_rise, bfr) - c0), 32'd33);
        check_eq("t5_frame", 32'(qget(q_frame, bfr)), 32'h0800);
        check_eq("t5_nfall", 32'(qget(q_nf, bfr)), 32'd16);
        check_eq("t5_tick_cyc", 32'(qget(q_tick, bt) - c0), 32'd34);
        mon_sel = 0;
        goto(c0 + 48);

        // Power-down bits.
        bfr = q_frame.size();
        send(0, 12'h000, 2'b11, c0);
        goto(c0 + 80);
`ifdef POWER_DOWN_EN
        check_eq("t6_frame_pd", 32'(qget(q_frame, bfr)), 32'h3000);
`else
        check_eq("t6_frame_nopd", 32'(qget(q_frame, bfr)), 32'h0000);
`endif

        check_eq("sclk_idle_high", 32'(sclk_bad), 32'd0);
        check_eq("busy_low_at_tick", 32'(busy_at_tick_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
